// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port cache-line memory arbiter.
package mem_arbiter_pkg;

    localparam int MEM_ADDR_WIDTH = 32;
    localparam int MEM_LINE_WIDTH = 256;

    typedef enum logic {
        IC = 1'b0,
        DC = 1'b1
    } mem_owner_e;

    typedef enum logic [2:0] {
        IDLE,
        MEM_READ,
        MEM_WRITE,
        RESPOND,
        RELEASE
    } mem_arb_state_e;

    typedef logic [MEM_LINE_WIDTH-1:0] line_t;

    function automatic mem_owner_e other_owner(input mem_owner_e owner);
        return (owner == IC) ? DC : IC;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response and memory control signals between the caches, the arbiter and RAM.
// Names are from the arbiter's point of view; the shared data bus is a separate inout.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);
    logic                  i_ic_read;
    logic [ADDR_WIDTH-1:0] i_ic_address;
    logic [LINE_WIDTH-1:0] o_ic_data;
    logic                  o_ic_ack;

    logic                  i_dc_read;
    logic                  i_dc_write;
    logic [ADDR_WIDTH-1:0] i_dc_address;
    logic [LINE_WIDTH-1:0] i_dc_data;
    logic [LINE_WIDTH-1:0] o_dc_data;
    logic                  o_dc_ack;

    logic                  o_mem_read;
    logic                  o_mem_write;
    logic [ADDR_WIDTH-1:0] o_mem_address;
    logic                  i_mem_ready;
    logic                  i_mem_done;

    modport slave (
        input  i_ic_read, i_ic_address,
        input  i_dc_read, i_dc_write, i_dc_address, i_dc_data,
        input  i_mem_ready, i_mem_done,
        output o_ic_data, o_ic_ack, o_dc_data, o_dc_ack,
        output o_mem_read, o_mem_write, o_mem_address
    );

    modport master (
        output i_ic_read, i_ic_address,
        output i_dc_read, i_dc_write, i_dc_address, i_dc_data,
        output i_mem_ready, i_mem_done,
        input  o_ic_data, o_ic_ack, o_dc_data, o_dc_ack,
        input  o_mem_read, o_mem_write, o_mem_address
    );

endinterface

// File: rtl/mem_arbiter_rr_arbiter2.sv
// Two-input round-robin grant: on a tie the requester that was not granted last wins.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,         // req[0] = IC, req[1] = DC
    input  mem_owner_e last_grant,
    output logic       gnt_valid,
    output mem_owner_e gnt_owner
);

    always_comb begin
        gnt_valid = |req;
        gnt_owner = last_grant;
        case (req)
            2'b01:   gnt_owner = IC;
            2'b10:   gnt_owner = DC;
            2'b11:   gnt_owner = other_owner(last_grant);
            default: gnt_owner = last_grant;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide memory bus between the icache fill port and the dcache
// fill/writeback port, one outstanding transaction at a time, round-robin on ties.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = MEM_ADDR_WIDTH,
    parameter int LINE_WIDTH = MEM_LINE_WIDTH
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    mem_arbiter_if.slave          bus,
    inout  wire  [LINE_WIDTH-1:0] io_mem_data
);

    mem_arb_state_e        state_q, state_d;
    mem_owner_e            owner_q, owner_d;
    mem_owner_e            last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0] ic_data_q, ic_data_d;
    logic [LINE_WIDTH-1:0] dc_data_q, dc_data_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic                  ic_ack_q, ic_ack_d;
    logic                  dc_ack_q, dc_ack_d;

    logic                  gnt_valid;
    mem_owner_e            gnt_owner;

    rr_arbiter2 u_rr (
        .req        ({bus.i_dc_read | bus.i_dc_write, bus.i_ic_read}),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .gnt_owner  (gnt_owner)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        ic_data_d    = ic_data_q;
        dc_data_d    = dc_data_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        ic_ack_d     = 1'b0;
        dc_ack_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    owner_d      = gnt_owner;
                    last_grant_d = gnt_owner;
                    if (gnt_owner == IC) begin
                        addr_d     = bus.i_ic_address;
                        mem_read_d = 1'b1;
                        state_d    = MEM_READ;
                    end else begin
                        addr_d = bus.i_dc_address;
                        // read+write together is a protocol violation; the write wins
                        if (bus.i_dc_write) begin
                            wdata_d     = bus.i_dc_data;
                            mem_write_d = 1'b1;
                            state_d     = MEM_WRITE;
                        end else begin
                            mem_read_d = 1'b1;
                            state_d    = MEM_READ;
                        end
                    end
                end
            end
            MEM_READ: begin
                if (bus.i_mem_ready) begin
                    mem_read_d = 1'b0;
                    if (owner_q == IC) begin
                        ic_data_d = io_mem_data;
                        ic_ack_d  = 1'b1;
                    end else begin
                        dc_data_d = io_mem_data;
                        dc_ack_d  = 1'b1;
                    end
                    state_d = RESPOND;
                end
            end
            MEM_WRITE: begin
                if (bus.i_mem_done) begin
                    mem_write_d = 1'b0;
                    dc_ack_d    = 1'b1;
                    state_d     = RESPOND;
                end
            end
            RESPOND: state_d = RELEASE;
            // memory clears ready/done one cycle after the strobe drops
            RELEASE: begin
                if (!bus.i_mem_ready && !bus.i_mem_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            owner_q      <= IC;
            last_grant_q <= IC;
            addr_q       <= '0;
            wdata_q      <= '0;
            ic_data_q    <= '0;
            dc_data_q    <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            ic_ack_q     <= 1'b0;
            dc_ack_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values and updates together.
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            ic_data_q    <= ic_data_d;
            dc_data_q    <= dc_data_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            ic_ack_q     <= ic_ack_d;
            dc_ack_q     <= dc_ack_d;
        end
    end

    assign io_mem_data       = mem_write_q ? wdata_q : {LINE_WIDTH{1'bz}};

    assign bus.o_mem_read    = mem_read_q;
    assign bus.o_mem_write   = mem_write_q;
    assign bus.o_mem_address = addr_q;
    assign bus.o_ic_data     = ic_data_q;
    assign bus.o_ic_ack      = ic_ack_q;
    assign bus.o_dc_data     = dc_data_q;
    assign bus.o_dc_ack      = dc_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized rounds
// checked against a transaction-level model (grant order, memory image, ack latency).
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    wire  [MEM_LINE_WIDTH-1:0] mem_data;

    int n_total = 0;
    int n_bad   = 0;

    mem_arbiter_if #(.ADDR_WIDTH(MEM_ADDR_WIDTH), .LINE_WIDTH(MEM_LINE_WIDTH)) bus_if ();

    mem_arbiter dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .bus         (bus_if),
        .io_mem_data (mem_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- RAM responder: 1-cycle registered, 16 lines ----------------
    line_t ram [16];
    line_t ram_rdata;

    function automatic line_t init_line(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(i);
        return (i == 1) ? {32{8'hA5}} : {8{w}};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_line(i);
            bus_if.i_mem_ready <= 1'b0;
            bus_if.i_mem_done  <= 1'b0;
            ram_rdata          <= '0;
        end else begin
            bus_if.i_mem_ready <= bus_if.o_mem_read;
            bus_if.i_mem_done  <= bus_if.o_mem_write;
            ram_rdata          <= ram[bus_if.o_mem_address[9:6]];
            if (bus_if.o_mem_write) ram[bus_if.o_mem_address[9:6]] <= mem_data;
        end
    end

    assign mem_data = bus_if.i_mem_ready ? ram_rdata : {MEM_LINE_WIDTH{1'bz}};

    // ---------------- reference model ----------------
    line_t      model_mem [16];
    mem_owner_e model_last;
    line_t      exp_ic_hold;
    line_t      exp_dc_hold;
    mem_owner_e order_q [$];
    int         first_strobe_cyc;
    int         ack_cyc [2];
    int         served_own [2];

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_mem[i] = init_line(i);
        model_last  = IC;
        exp_ic_hold = '0;
        exp_dc_hold = '0;
    endtask

    function automatic int idx(input logic [31:0] a);
        return int'(a[9:6]);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [3:0] ix;
        ix = 4'($urandom_range(0, 15));
        return {22'h0, ix, 6'h0};
    endfunction

    function automatic line_t rand_line();
        line_t l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic clear_reqs();
        bus_if.i_ic_read    = 1'b0;
        bus_if.i_ic_address = '0;
        bus_if.i_dc_read    = 1'b0;
        bus_if.i_dc_write   = 1'b0;
        bus_if.i_dc_address = '0;
        bus_if.i_dc_data    = '0;
    endtask

    // Raise the requested ports together, then follow the bus until every request is acked.
    task automatic run_round(input bit ic_en, input logic [31:0] ic_a,
                             input bit dc_en, input bit dc_rd, input bit dc_wr,
                             input logic [31:0] dc_a, input line_t dc_w);
        mem_owner_e exp_q [$];
        mem_owner_e cur;
        int         cyc;
        int         tail;
        int         n_served;
        bit         drop_ic;
        bit         drop_dc;
        logic [1:0] acks;
        if (ic_en && dc_en) begin
            exp_q.push_back(other_owner(model_last));
            exp_q.push_back(model_last);
        end else if (ic_en) begin
            exp_q.push_back(IC);
        end else if (dc_en) begin
            exp_q.push_back(DC);
        end
        first_strobe_cyc = -1;
        ack_cyc          = '{-1, -1};
        served_own       = '{-1, -1};
        n_served         = 0;
        @(posedge clk); #1;
        bus_if.i_ic_read    = ic_en;
        bus_if.i_ic_address = ic_a;
        bus_if.i_dc_read    = dc_en & dc_rd;
        bus_if.i_dc_write   = dc_en & dc_wr;
        bus_if.i_dc_address = dc_a;
        bus_if.i_dc_data    = dc_w;
        cyc  = 0;
        tail = 0;
        while ((exp_q.size() != 0 || tail < 4) && cyc < 60) begin
            @(negedge clk);
            drop_ic = 1'b0;
            drop_dc = 1'b0;
            acks    = {bus_if.o_ic_ack, bus_if.o_dc_ack};
            if (exp_q.size() != 0) begin
                cur = exp_q[0];
                if (bus_if.o_mem_read || bus_if.o_mem_write) begin
                    if (first_strobe_cyc < 0) first_strobe_cyc = cyc;
                    check("mem_addr", bus_if.o_mem_address, (cur == IC) ? ic_a : dc_a);
                    check("strobe_kind", {bus_if.o_mem_read, bus_if.o_mem_write},
                          (cur == DC && dc_wr) ? 2'b01 : 2'b10);
                    if (bus_if.o_mem_write) check("wr_bus", mem_data, dc_w);
                end
                if (acks != 2'b00) begin
                    check("ack_owner", acks, (cur == IC) ? 2'b10 : 2'b01);
                    if (cur == IC) begin
                        exp_ic_hold = model_mem[idx(ic_a)];
                        check("ic_data", bus_if.o_ic_data, exp_ic_hold);
                        drop_ic = 1'b1;
                    end else begin
                        if (dc_wr) begin
                            model_mem[idx(dc_a)] = dc_w;
                        end else begin
                            exp_dc_hold = model_mem[idx(dc_a)];
                            check("dc_data", bus_if.o_dc_data, exp_dc_hold);
                        end
                        drop_dc = 1'b1;
                    end
                    ack_cyc[n_served]    = cyc;
                    served_own[n_served] = int'(cur);
                    n_served++;
                    model_last = cur;
                    void'(exp_q.pop_front());
                end
            end else begin
                check("idle_quiet", {acks, bus_if.o_mem_read, bus_if.o_mem_write}, 4'b0000);
                tail++;
            end
            @(posedge clk); #1;
            if (drop_ic) bus_if.i_ic_read = 1'b0;
            if (drop_dc) begin
                bus_if.i_dc_read  = 1'b0;
                bus_if.i_dc_write = 1'b0;
            end
            cyc++;
        end
        check("round_done", 256'(exp_q.size()), 256'd0);
        check("ic_hold", bus_if.o_ic_data, exp_ic_hold);
        check("dc_hold", bus_if.o_dc_data, exp_dc_hold);
    endtask

    // Requester that re-raises a new read two cycles after each ack.
    task automatic agent(input bit is_dc, input int n);
        for (int k = 0; k < n; k++) begin
            logic [31:0] a;
            bit          got;
            a = rand_addr();
            if (is_dc) begin
                bus_if.i_dc_address = a;
                bus_if.i_dc_read    = 1'b1;
            end else begin
                bus_if.i_ic_address = a;
                bus_if.i_ic_read    = 1'b1;
            end
            got = 1'b0;
            for (int w = 0; w < 60 && !got; w++) begin
                @(negedge clk);
                got = is_dc ? bus_if.o_dc_ack : bus_if.o_ic_ack;
            end
            check(is_dc ? "dc_agent_ack" : "ic_agent_ack", 256'(got), 256'd1);
            if (got) begin
                order_q.push_back(is_dc ? DC : IC);
                if (is_dc) begin
                    exp_dc_hold = model_mem[idx(a)];
                    check("dc_agent_data", bus_if.o_dc_data, exp_dc_hold);
                end else begin
                    exp_ic_hold = model_mem[idx(a)];
                    check("ic_agent_data", bus_if.o_ic_data, exp_ic_hold);
                end
            end
            @(posedge clk); #1;
            if (is_dc) bus_if.i_dc_read = 1'b0;
            else       bus_if.i_ic_read = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        line_t wline;
        bit    seen;
        rst = 1'b1;
        clear_reqs();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_read",  256'(bus_if.o_mem_read), 256'd0);
        check("rst_mem_write", 256'(bus_if.o_mem_write), 256'd0);
        check("rst_mem_addr",  256'(bus_if.o_mem_address), 256'd0);
        check("rst_ic_ack",    256'(bus_if.o_ic_ack), 256'd0);
        check("rst_dc_ack",    256'(bus_if.o_dc_ack), 256'd0);
        check("rst_ic_data",   bus_if.o_ic_data, 256'd0);
        check("rst_dc_data",   bus_if.o_dc_data, 256'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // IC read alone: strobe after edge 1, ack after edge 3
        run_round(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'h0, '0);
        check("t1_strobe_lat", 256'(first_strobe_cyc), 256'd1);
        check("t1_ack_lat",    256'(ack_cyc[0]), 256'd3);
        check("t1_ic_data",    bus_if.o_ic_data, {32{8'hA5}});

        // DC write then IC read-back of the same line
        wline = 256'h11223344556677889900AABBCCDDEEFF_11223344556677889900AABBCCDDEEFF;
        run_round(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h80, wline);
        check("t2_ack_lat", 256'(ack_cyc[0]), 256'd3);
        check("t2_ram",     ram[2], wline);
        run_round(1'b1, 32'h80, 1'b0, 1'b0, 1'b0, 32'h0, '0);
        check("t2_readback", bus_if.o_ic_data, wline);

        // reset while a read is outstanding
        @(posedge clk); #1;
        bus_if.i_ic_address = 32'h100;
        bus_if.i_ic_read    = 1'b1;
        seen = 1'b0;
        for (int w = 0; w < 10 && !seen; w++) begin
            @(negedge clk);
            seen = bus_if.o_mem_read;
        end
        check("t5_strobe_seen", 256'(seen), 256'd1);
        rst = 1'b1;
        #1;
        check("t5_read_drop", 256'(bus_if.o_mem_read), 256'd0);
        check("t5_no_ack",    256'({bus_if.o_ic_ack, bus_if.o_dc_ack}), 256'd0);
        check("t5_ic_data",   bus_if.o_ic_data, 256'd0);
        bus_if.i_ic_read = 1'b0;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            check("t5_rst_quiet", 256'({bus_if.o_ic_ack, bus_if.o_dc_ack, bus_if.o_mem_read}), 256'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        // tie right after reset: DC first, then IC (also the reissued read)
        run_round(1'b1, 32'h140, 1'b1, 1'b1, 1'b0, 32'h180, '0);
        check("t3_first_dc",  256'(served_own[0]), 256'(int'(DC)));
        check("t3_second_ic", 256'(served_own[1]), 256'(int'(IC)));
        check("t3_lat2",      256'(ack_cyc[1]), 256'd8);

        // both requesters continuously active: strict alternation
        order_q.delete();
        @(posedge clk); #1;
        fork
            agent(1'b0, 3);
            agent(1'b1, 3);
        join
        check("t4_count", 256'(order_q.size()), 256'd6);
        for (int i = 0; i < 6 && i < order_q.size(); i++) begin
            check("t4_order", 256'(int'(order_q[i])), 256'((i % 2 == 0) ? int'(DC) : int'(IC)));
        end
        if (order_q.size() != 0) model_last = order_q[order_q.size()-1];
        repeat (4) @(posedge clk);

        // read and write together are treated as a write
        wline = rand_line();
        run_round(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h200, wline);
        check("t6_ack_lat", 256'(ack_cyc[0]), 256'd3);
        check("t6_ram",     ram[8], wline);

        // randomized rounds
        for (int r = 0; r < 40; r++) begin
            bit          ic_en;
            bit          dc_en;
            bit          dc_wr;
            bit          dc_rd;
            logic [31:0] ia;
            logic [31:0] da;
            ic_en = 1'($urandom_range(0, 1));
            dc_en = ic_en ? 1'($urandom_range(0, 1)) : 1'b1;
            dc_wr = 1'($urandom_range(0, 1));
            dc_rd = dc_wr ? ($urandom_range(0, 3) == 0) : 1'b1;
            ia    = rand_addr();
            da    = rand_addr();
            wline = rand_line();
            run_round(ic_en, ia, dc_en, dc_rd, dc_wr, da, wline);
            if (ic_en && dc_en) begin
                check("rnd_lat1", 256'(ack_cyc[0]), 256'd3);
                check("rnd_lat2", 256'(ack_cyc[1]), 256'd8);
            end else begin
                check("rnd_lat", 256'(ack_cyc[0]), 256'd3);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single line-wide memory bus (32-bit address, 256-bit data, read/write/ready/done) between the instruction-cache fill port and the data-cache fill/writeback port.
- Round-robin arbitration and one outstanding transaction at a time.
- Registered memory-side control; response data is captured into a register and returned to the winning requester.
- Sits between the two caches and RAM.

Parameters:
- ADDR_WIDTH, 32, address width on all ports.
- LINE_WIDTH, 256, data width on all ports (one cache line).

Ports:
- i_clock  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_ic_read  in  1  icache line-read request (level, held until o_ic_ack)
- i_ic_address  in  ADDR_WIDTH  icache request address
- o_ic_data  out  LINE_WIDTH  read line to icache
- o_ic_ack  out  1  one-cycle pulse: o_ic_data valid, request complete
- i_dc_read  in  1  dcache line-read request (level)
- i_dc_write  in  1  dcache line-write request (level)
- i_dc_address  in  ADDR_WIDTH  dcache request address
- i_dc_data  in  LINE_WIDTH  dcache write line
- o_dc_data  out  LINE_WIDTH  read line to dcache
- o_dc_ack  out  1  one-cycle pulse: read data valid or write complete
- o_mem_read  out  1  memory read strobe (level)
- o_mem_write  out  1  memory write strobe (level)
- o_mem_address  out  ADDR_WIDTH  memory address
- io_mem_data  inout  LINE_WIDTH  shared memory data bus
- i_mem_ready  in  1  memory read data valid
- i_mem_done  in  1  memory write complete

Behaviour:
- Reset (async, i_reset=1): state IDLE; o_mem_read=0, o_mem_write=0, o_mem_address=0, o_ic_ack=0, o_dc_ack=0, o_ic_data=0, o_dc_data=0, io_mem_data released to 'z; last_grant=IC, so DC wins the first tie.
- io_mem_data is driven with the latched write line only while o_mem_write=1; otherwise it is 'z.
- FSM states: IDLE, MEM_READ, MEM_WRITE, RESPOND, RELEASE.
- IDLE:
  - Evaluates requests each cycle.
  - DC is requesting if i_dc_read|i_dc_write; IC is requesting if i_ic_read.
  - If both request, grant the requester that is not last_grant; otherwise grant the sole requester.
  - On grant: latch owner, address and (for a DC write) i_dc_data; update last_grant.
  - Next state: MEM_WRITE if i_dc_write, else MEM_READ.
  - If i_dc_read and i_dc_write are both high, treat it as a write (protocol violation, no error flag).
- MEM_READ:
  - o_mem_read=1, o_mem_address=latched address.
  - On i_mem_ready=1: capture io_mem_data into the owner's o_*_data register, drop o_mem_read, go to RESPOND.
- MEM_WRITE:
  - o_mem_write=1, bus driven.
  - On i_mem_done=1: drop o_mem_write, release the bus, go to RESPOND.
- RESPOND: assert the owner's o_*_ack for exactly one cycle; go to RELEASE.
- RELEASE:
  - Wait until i_mem_ready=0 and i_mem_done=0, because memory clears these one cycle after the strobe drops; then go to IDLE.
  - No new grant is issued before RELEASE exits.
- o_ic_data and o_dc_data hold their last captured value until overwritten by the next read for that requester.
- Requester contract:
  - Hold request, address and data stable until ack.
  - Deassert the request in the cycle after ack; a request still high when the FSM reaches IDLE is a new request.
  - Request inputs are sampled only in IDLE; changes in other states are ignored.
- Latency against a 1-cycle-registered RAM: request sampled at edge 0, o_mem_read high after edge 1, i_mem_ready high after edge 2, ack high after edge 3, IDLE after edge 5 (RELEASE takes 1 cycle). Write path has the same timing.
- Address is forwarded unmodified; line alignment is the memory's responsibility.
- Reset mid-transaction: strobes drop immediately (async) and the transaction is lost with no ack; requesters reissue after reset.
- Starvation bound: with both requesters continuously active, each is served at least every second transaction.

Decomposition:
- pkg_defines gains:
  - mem_owner_e (IC, DC);
  - mem_arb_state_e (IDLE, MEM_READ, MEM_WRITE, RESPOND, RELEASE);
  - line_t (LINE_WIDTH data).
- Sub-module rr_arbiter2: 2-input round-robin grant from req[1:0] and last_grant, purely combinational. Everything else stays in mem_arbiter.

Test Plan:
- IC read alone, addr 0x0000_0040, RAM line pattern 0xA5…: o_mem_read high cycle 1 → o_ic_ack single pulse at cycle 3 with o_ic_data = RAM line; o_dc_ack stays 0.
- DC write, addr 0x0000_0080, data 0x1122…FF: io_mem_data driven only while o_mem_write=1 → o_dc_ack pulse; a subsequent IC read of 0x80 returns 0x1122…FF.
- IC and DC read requests both raised in the same cycle right after reset → DC granted first; IC acked one transaction later; order DC, IC.
- Both requesters held continuously for 6 transactions → grants alternate DC, IC, DC, IC, DC, IC.
- Assert i_reset while in MEM_READ → o_mem_read=0 in the same cycle, no ack, state IDLE; a read reissued after reset completes normally.
- i_dc_read=i_dc_write=1 → write performed (o_mem_write=1, o_mem_read never high), single o_dc_ack.
